// File: rtl/line_fill_controller.sv
// line_fill_controller: cache line miss handler.
// Chooses a victim way, optionally writes back a dirty victim, then fills the
// line from memory beat by beat and commits the new tag.
// Build option: define WRITEBACK_EN to include the eviction path
// (EVICT_REQ/EVICT_DATA). Without it, way_dirty is ignored and every miss is
// a direct fill.
module line_fill_controller #(
  parameter int unsigned WAYS       = 8,
  parameter int unsigned TAG_BITS   = 10,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned BEAT_BITS  = 64,
  parameter int unsigned BEATS      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  // miss request
  input  logic                             miss_valid,
  output logic                             miss_ready,
  input  logic [TAG_BITS-1:0]              miss_tag,
  input  logic [INDEX_BITS-1:0]            miss_index,
  // set state at miss_index
  input  logic [WAYS-1:0]                  way_valid,
  input  logic [WAYS-1:0]                  way_dirty,
  input  logic [WAYS*TAG_BITS-1:0]         way_tags,
  // memory request channel
  output logic                             mem_req_valid,
  input  logic                             mem_req_ready,
  output logic                             mem_req_we,
  output logic [TAG_BITS+INDEX_BITS-1:0]   mem_req_addr,
  // memory data channels
  input  logic                             mem_rdata_valid,
  input  logic [BEAT_BITS-1:0]             mem_rdata,
  output logic                             mem_wdata_valid,
  input  logic                             mem_wdata_ready,
  output logic [BEAT_BITS-1:0]             mem_wdata,
  // data array port
  output logic [$clog2(WAYS)-1:0]          arr_way,
  output logic [INDEX_BITS-1:0]            arr_index,
  output logic [$clog2(BEATS)-1:0]         arr_beat,
  input  logic [BEAT_BITS-1:0]             arr_rd_data,
  output logic                             arr_we,
  output logic [BEAT_BITS-1:0]             arr_wdata,
  // tag array update / completion
  output logic                             tag_we,
  output logic                             fill_done,
  output logic [$clog2(WAYS)-1:0]          fill_way
);

  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned BEAT_W = $clog2(BEATS);
  localparam int unsigned ADDR_W = TAG_BITS + INDEX_BITS;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
`ifdef WRITEBACK_EN
    S_EVICT_REQ  = 3'd1,
    S_EVICT_DATA = 3'd2,
`endif
    S_FILL_REQ   = 3'd3,
    S_FILL_DATA  = 3'd4,
    S_UPDATE     = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_miss_ready;
  logic                  r_req_valid;
  logic [ADDR_W-1:0]     r_req_addr;
  logic [BEAT_W-1:0]     r_beat;
  logic [WAY_W-1:0]      r_rr;
  logic [WAY_W-1:0]      r_victim;
  logic [INDEX_BITS-1:0] r_index;
  logic                  r_update;

  logic [WAY_W-1:0]      w_victim;
  logic                  w_all_valid;
  logic [WAY_W-1:0]      w_rr_next;

`ifdef WRITEBACK_EN
  logic                  r_req_we;
  logic                  r_wdata_valid;
  logic [TAG_BITS-1:0]   r_tag;
  logic [TAG_BITS-1:0]   w_victim_tag;
  logic                  w_victim_dirty;
`endif

  assign w_all_valid = &way_valid;
  assign w_rr_next   = (r_rr == LAST_WAY) ? '0 : r_rr + WAY_W'(1);

  // Victim: lowest invalid way, else the round-robin way.
  always_comb begin
    w_victim = r_rr;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        w_victim = WAY_W'(w);
      end
    end
  end

`ifdef WRITEBACK_EN
  // Tag and dirty status of the chosen victim, needed to decide on eviction.
  always_comb begin
    w_victim_tag   = '0;
    w_victim_dirty = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (w_victim == WAY_W'(w)) begin
        w_victim_tag   = way_tags[w*TAG_BITS +: TAG_BITS];
        w_victim_dirty = way_valid[w] & way_dirty[w];
      end
    end
  end
`endif

  // Miss-handling FSM; all handshake and status outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_miss_ready  <= 1'b1;
      r_req_valid   <= 1'b0;
      r_req_addr    <= '0;
      r_beat        <= '0;
      r_rr          <= '0;
      r_victim      <= '0;
      r_index       <= '0;
      r_update      <= 1'b0;
`ifdef WRITEBACK_EN
      r_req_we      <= 1'b0;
      r_wdata_valid <= 1'b0;
      r_tag         <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (miss_valid && r_miss_ready) begin
            r_index      <= miss_index;
            r_victim     <= w_victim;
            r_miss_ready <= 1'b0;
            r_req_valid  <= 1'b1;
            if (w_all_valid) begin
              r_rr <= w_rr_next;
            end
`ifdef WRITEBACK_EN
            r_tag <= miss_tag;
            if (w_victim_dirty) begin
              r_state    <= S_EVICT_REQ;
              r_req_we   <= 1'b1;
              r_req_addr <= {w_victim_tag, miss_index};
            end else
`endif
            begin
              r_state    <= S_FILL_REQ;
              r_req_addr <= {miss_tag, miss_index};
            end
          end
        end

`ifdef WRITEBACK_EN
        S_EVICT_REQ: begin
          if (mem_req_ready) begin
            r_req_valid   <= 1'b0;
            r_req_we      <= 1'b0;
            r_beat        <= '0;
            r_wdata_valid <= 1'b1;
            r_state       <= S_EVICT_DATA;
          end
        end

        S_EVICT_DATA: begin
          if (mem_wdata_ready) begin
            if (r_beat == LAST_BEAT) begin
              r_beat        <= '0;
              r_wdata_valid <= 1'b0;
              r_req_valid   <= 1'b1;
              r_req_addr    <= {r_tag, r_index};
              r_state       <= S_FILL_REQ;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end
`endif

        S_FILL_REQ: begin
          if (mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_beat      <= '0;
            r_state     <= S_FILL_DATA;
          end
        end

        S_FILL_DATA: begin
          if (mem_rdata_valid) begin
            if (r_beat == LAST_BEAT) begin
              r_beat   <= '0;
              r_update <= 1'b1;
              r_state  <= S_UPDATE;
            end else begin
              r_beat <= r_beat + BEAT_W'(1);
            end
          end
        end

        S_UPDATE: begin
          r_update     <= 1'b0;
          r_miss_ready <= 1'b1;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state      <= S_IDLE;
          r_miss_ready <= 1'b1;
          r_req_valid  <= 1'b0;
          r_update     <= 1'b0;
        end
      endcase
    end
  end

  assign miss_ready    = r_miss_ready;
  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign arr_way       = r_victim;
  assign arr_index     = r_index;
  assign arr_beat      = r_beat;
  assign tag_we        = r_update;
  assign fill_done     = r_update;
  assign fill_way      = r_victim;

  // Fill beats go straight into the array in the cycle they arrive.
  assign arr_we    = (r_state == S_FILL_DATA) && mem_rdata_valid;
  assign arr_wdata = arr_we ? mem_rdata : '0;

`ifdef WRITEBACK_EN
  // Writeback data is the combinational array read at the held beat address.
  assign mem_req_we      = r_req_we;
  assign mem_wdata_valid = r_wdata_valid;
  assign mem_wdata       = r_wdata_valid ? arr_rd_data : '0;
`else
  assign mem_req_we      = 1'b0;
  assign mem_wdata_valid = 1'b0;
  assign mem_wdata       = '0;

  logic w_unused;
  assign w_unused = ^{way_dirty, way_tags, arr_rd_data, mem_wdata_ready};
`endif

endmodule

// File: tb/tb_line_fill_controller.sv
// Directed bench for line_fill_controller with a transaction-level model.
module tb_line_fill_controller;

  localparam int WAYS = 8, TAG_BITS = 10, INDEX_BITS = 6, BEAT_BITS = 64, BEATS = 8;
  localparam int WAY_W = 3, BEAT_W = 3, ADDR_W = 16;
`ifdef WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
  } req_t;

  logic clk, rst_n;
  logic miss_valid, miss_ready;
  logic [TAG_BITS-1:0] miss_tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic [WAYS-1:0] way_valid, way_dirty;
  logic [WAYS*TAG_BITS-1:0] way_tags;
  logic mem_req_valid, mem_req_ready, mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic mem_rdata_valid, mem_wdata_valid, mem_wdata_ready;
  logic [BEAT_BITS-1:0] mem_rdata, mem_wdata, arr_rd_data, arr_wdata;
  logic [WAY_W-1:0] arr_way, fill_way;
  logic [INDEX_BITS-1:0] arr_index;
  logic [BEAT_W-1:0] arr_beat;
  logic arr_we, tag_we, fill_done;

  line_fill_controller dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_tag(miss_tag), .miss_index(miss_index),
    .way_valid(way_valid), .way_dirty(way_dirty), .way_tags(way_tags),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
    .arr_way(arr_way), .arr_index(arr_index), .arr_beat(arr_beat), .arr_rd_data(arr_rd_data),
    .arr_we(arr_we), .arr_wdata(arr_wdata),
    .tag_we(tag_we), .fill_done(fill_done), .fill_way(fill_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array contents: every (way, index, beat) holds a distinct recognisable word.
  function automatic logic [63:0] evict_word(input logic [WAY_W-1:0] w,
                                             input logic [INDEX_BITS-1:0] i,
                                             input logic [BEAT_W-1:0] b);
    return {8'hEE, 5'd0, w, 2'd0, i, 5'd0, b, 32'hC0DE_A5A5};
  endfunction

  assign arr_rd_data = evict_word(arr_way, arr_index, arr_beat);

  function automatic int pick_victim(input logic [WAYS-1:0] v, input int rr);
    int r;
    r = -1;
    for (int i = 0; i < WAYS; i++) if (!v[i] && r < 0) r = i;
    if (r < 0) r = rr;
    return r;
  endfunction

  int n_vec = 0, n_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state and DUT observation counters
  int phase = 0, m_rr = 0, m_victim = 0, wbeats = 0, rbeats = 0, t_acc = 0, cyc = 0;
  logic [INDEX_BITS-1:0] m_index = '0;
  req_t q[$];
  req_t pr;
  int n_acc = 0, n_done = 0, n_arrwe = 0, n_reqcyc = 0, n_wreq = 0, n_wbeats = 0, n_rbeats = 0;
  int obs_fill_way = -1, last_lat = 0;
  logic [ADDR_W-1:0] last_waddr = '0, last_raddr = '0;

  // phase: 0 idle, 1 request pending, 2 writeback data, 3 fill data, 4 update
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_ctrl", 64'({mem_req_valid, mem_req_we, mem_wdata_valid, arr_we, tag_we, fill_done}), 64'd0);
      chk("rst_addr", 64'({mem_req_addr, arr_way, arr_index, arr_beat, fill_way}), 64'd0);
      chk("rst_data", mem_wdata | arr_wdata, 64'd0);
      phase = 0; m_rr = 0; q.delete();
    end else begin
      chk("miss_ready", 64'(miss_ready), 64'(phase == 0));
      chk("req_valid", 64'(mem_req_valid), 64'(phase == 1));
      chk("wdata_valid", 64'(mem_wdata_valid), 64'(phase == 2));
      chk("arr_we", 64'(arr_we), 64'(phase == 3 && mem_rdata_valid));
      chk("tag_we", 64'(tag_we), 64'(phase == 4));
      chk("fill_done", 64'(fill_done), 64'(phase == 4));
      if (phase == 1 && q.size() > 0) begin
        chk("req_we", 64'(mem_req_we), 64'(q[0].we));
        chk("req_addr", 64'(mem_req_addr), 64'(q[0].addr));
      end
      if (phase != 0) chk("arr_way_index", 64'({arr_way, arr_index}), 64'({WAY_W'(m_victim), m_index}));
      if (phase == 2) begin
        chk("wb_beat", 64'(arr_beat), 64'(wbeats));
        chk("wb_data", mem_wdata, evict_word(WAY_W'(m_victim), m_index, BEAT_W'(wbeats)));
      end
      if (phase == 3 && mem_rdata_valid) begin
        chk("fill_beat", 64'(arr_beat), 64'(rbeats));
        chk("fill_data", arr_wdata, mem_rdata);
      end
      if (phase == 4) chk("fill_way", 64'(fill_way), 64'(m_victim));

      // DUT-side observation counters
      if (arr_we) n_arrwe++;
      if (mem_req_valid) n_reqcyc++;
      if (mem_wdata_valid && mem_wdata_ready) n_wbeats++;
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_we) begin n_wreq++; last_waddr = mem_req_addr; end
        else last_raddr = mem_req_addr;
      end

      // model progression
      case (phase)
        0: if (miss_valid && miss_ready) begin
             m_victim = pick_victim(way_valid, m_rr);
             if (&way_valid) m_rr = (m_rr + 1) % WAYS;
             m_index = miss_index;
             if (WB && way_valid[m_victim] && way_dirty[m_victim]) begin
               pr = {1'b1, way_tags[m_victim*TAG_BITS +: TAG_BITS], miss_index};
               q.push_back(pr);
             end
             pr = {1'b0, miss_tag, miss_index};
             q.push_back(pr);
             phase = 1; t_acc = cyc; n_acc++;
           end
        1: if (mem_req_valid && mem_req_ready && q.size() > 0) begin
             pr = q.pop_front();
             if (pr.we) begin phase = 2; wbeats = 0; end
             else begin phase = 3; rbeats = 0; end
           end
        2: if (mem_wdata_valid && mem_wdata_ready) begin
             wbeats++;
             if (wbeats == BEATS) phase = 1;
           end
        3: if (mem_rdata_valid) begin
             rbeats++; n_rbeats++;
             if (rbeats == BEATS) phase = 4;
           end
        default: begin
             phase = 0; n_done++; obs_fill_way = int'(fill_way); last_lat = cyc - t_acc;
           end
      endcase
    end
  end

  // Memory responder
  int stall_cfg = 0, load_id = 0;
  bit rv_tog = 1'b0, wr_tog = 1'b0;
  initial begin
    int stall_left, seen_id;
    stall_left = 0; seen_id = 0;
    mem_req_ready = 1'b0; mem_rdata_valid = 1'b0; mem_wdata_ready = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (load_id != seen_id) begin stall_left = stall_cfg; seen_id = load_id; end
      mem_rdata       = {$urandom, $urandom};
      mem_rdata_valid = rv_tog ? ~mem_rdata_valid : 1'b1;
      mem_wdata_ready = wr_tog ? ~mem_wdata_ready : 1'b1;
      if (mem_req_valid && stall_left > 0) begin
        mem_req_ready = 1'b0; stall_left--;
      end else begin
        mem_req_ready = mem_req_valid;
      end
    end
  end

  task automatic start_miss(input logic [9:0] tag, input logic [5:0] idx, input logic [7:0] vv,
                            input logic [7:0] vd, input int stall, input bit rvt, input bit wrt);
    int a0;
    @(posedge clk); #1;
    stall_cfg = stall; load_id++; rv_tog = rvt; wr_tog = wrt;
    miss_tag = tag; miss_index = idx; way_valid = vv; way_dirty = vd; miss_valid = 1'b1;
    a0 = n_acc;
    for (int k = 0; k < 50 && n_acc == a0; k++) @(posedge clk);
    #1 miss_valid = 1'b0;
    chk("accept", 64'(n_acc - a0), 64'd1);
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 400 && n_done == d0; k++) @(posedge clk);
    chk("done", 64'(n_done - d0), 64'd1);
  endtask

  task automatic do_miss(input logic [9:0] tag, input logic [5:0] idx, input logic [7:0] vv,
                         input logic [7:0] vd, input int stall, input bit rvt, input bit wrt);
    int d0;
    d0 = n_done;
    start_miss(tag, idx, vv, vd, stall, rvt, wrt);
    wait_done(d0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    n_miss++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    int d0, r0, base;
    rst_n = 1'b0; miss_valid = 1'b0; miss_tag = '0; miss_index = '0;
    way_valid = '0; way_dirty = '0;
    for (int w = 0; w < WAYS; w++)
      way_tags[w*TAG_BITS +: TAG_BITS] = (w == 0) ? 10'h2A : 10'(10'h100 + w);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_miss_ready", 64'(miss_ready), 64'd1);
    chk("reset_outputs", 64'({mem_req_valid, tag_we, fill_done, arr_we, mem_wdata_valid}), 64'd0);

    // Clean miss into the one invalid way
    base = n_arrwe;
    do_miss(10'h155, 6'd3, 8'b1111_0111, 8'h00, 0, 1'b0, 1'b0);
    chk("t1_victim", 64'(obs_fill_way), 64'd3);
    chk("t1_fill_addr", 64'(last_raddr), 64'h5543);
    chk("t1_latency", 64'(last_lat), 64'd10);
    chk("t1_arr_beats", 64'(n_arrwe - base), 64'd8);

    // Round-robin over a full set; second miss stalls the request 5 cycles
    do_miss(10'h011, 6'd7, 8'hFF, 8'h00, 0, 1'b0, 1'b0);
    chk("t2_victim0", 64'(obs_fill_way), 64'd0);
    base = n_reqcyc;
    do_miss(10'h022, 6'd8, 8'hFF, 8'h00, 5, 1'b0, 1'b0);
    chk("t2_victim1", 64'(obs_fill_way), 64'd1);
    chk("t2_req_hold_cycles", 64'(n_reqcyc - base), 64'd6);
    base = n_arrwe;
    do_miss(10'h033, 6'd9, 8'hFF, 8'h00, 0, 1'b1, 1'b0);
    chk("t2_victim2", 64'(obs_fill_way), 64'd2);
    chk("t2_gappy_beats", 64'(n_arrwe - base), 64'd8);

    // Reset in the middle of a fill
    d0 = n_done; r0 = n_rbeats;
    start_miss(10'h0F0, 6'd9, 8'hFF, 8'h00, 0, 1'b0, 1'b0);
    for (int k = 0; k < 200 && (n_rbeats - r0) < 5; k++) @(posedge clk);
    chk("t3_beats_before_reset", 64'(n_rbeats - r0), 64'd5);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t3_no_done", 64'(n_done - d0), 64'd0);
    chk("t3_ready_after_release", 64'(miss_ready), 64'd1);
    do_miss(10'h0F1, 6'd9, 8'hFF, 8'h00, 0, 1'b0, 1'b0);
    chk("t3_victim_after_reset", 64'(obs_fill_way), 64'd0);

    // Dirty victim: writeback when built in, direct fill otherwise
    pulse_reset();
    r0 = n_wreq; base = n_wbeats;
    if (WB) begin
      do_miss(10'h3C1, 6'd5, 8'hFF, 8'h01, 2, 1'b0, 1'b1);
      chk("t4_wreq_count", 64'(n_wreq - r0), 64'd1);
      chk("t4_wreq_addr", 64'(last_waddr), 64'h0A85);
      chk("t4_wbeats", 64'(n_wbeats - base), 64'd8);
    end else begin
      do_miss(10'h3C1, 6'd5, 8'hFF, 8'hFF, 2, 1'b0, 1'b1);
      chk("t4_wreq_count", 64'(n_wreq - r0), 64'd0);
      chk("t4_wbeats", 64'(n_wbeats - base), 64'd0);
    end
    chk("t4_fill_addr", 64'(last_raddr), 64'hF045);
    chk("t4_victim", 64'(obs_fill_way), 64'd0);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
